// File: rtl/apb_reg_bank.sv
// APB slave register bank: CTRL registers, STATUS, PEND/IEN interrupts.
// Programmable wait states; PSLVERR on unmapped register indices.
module apb_reg_bank #(
  parameter int NUM_REGS    = 4,
  parameter int DATA_W      = 8,
  parameter int SEL_LSB     = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [31:0]                pwdata,
  output logic                       pready,
  output logic [31:0]                prdata,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] ctrl_out,
  input  logic [DATA_W-1:0]          status_in,
  input  logic [DATA_W-1:0]          event_in,
  output logic                       irq
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 wcnt_q, wcnt_d;
  logic [NUM_REGS*DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0]          status_q, status_d;
  logic [DATA_W-1:0]          pend_q, pend_d;
  logic [DATA_W-1:0]          ien_q, ien_d;
  logic [DATA_W-1:0]          ev_q, ev_d;
  logic                       irq_q, irq_d;

  logic [31:0]       idx;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rval;
  logic [DATA_W-1:0] clr;
  logic              mapped;
  logic              wr;

  assign idx   = 32'(paddr[30:SEL_LSB]);
  assign wdata = pwdata[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          wcnt_d  = 3'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (wcnt_q != 3'd0) begin
            wcnt_d = wcnt_q - 3'd1;
          end else begin
            pready  = rst_n;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mapped = 1'b1;
    rval   = '0;
    unique case (1'b1)
      (idx < 32'(NUM_REGS)): begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (idx == 32'(k)) rval = ctrl_q[k*DATA_W +: DATA_W];
        end
      end
      (idx == 32'(NUM_REGS)):     rval = status_q;
      (idx == 32'(NUM_REGS + 1)): rval = pend_q;
      (idx == 32'(NUM_REGS + 2)): rval = ien_q;
      default:                    mapped = 1'b0;
    endcase
  end

  always_comb begin
    prdata = '0;
    if (pready) prdata[DATA_W-1:0] = rval;
    pslverr = pready & ~mapped;
  end

  assign wr = pready & pwrite & mapped;

  always_comb begin
    ctrl_d = ctrl_q;
    ien_d  = ien_q;
    clr    = '0;
    if (wr) begin
      unique case (1'b1)
        (idx < 32'(NUM_REGS)): begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == 32'(k)) ctrl_d[k*DATA_W +: DATA_W] = wdata;
          end
        end
        (idx == 32'(NUM_REGS + 1)): clr   = wdata;
        (idx == 32'(NUM_REGS + 2)): ien_d = wdata;
        default: ;
      endcase
    end
    // Rising-edge set takes priority over a same-cycle W1C clear
    pend_d   = (pend_q & ~clr) | (event_in & ~ev_q);
    status_d = status_in;
    ev_d     = event_in;
    irq_d    = |(pend_q & ien_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      ctrl_q   <= '0;
      status_q <= '0;
      pend_q   <= '0;
      ien_q    <= '0;
      ev_q     <= event_in;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      pend_q   <= pend_d;
      ien_q    <= ien_d;
      ev_q     <= ev_d;
      irq_q    <= irq_d;
    end
  end

  assign ctrl_out = ctrl_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: three instances with 0, 3 and 2 wait states.
// Expected read results are queued before each transfer and popped after.
module tb_apb_reg_bank;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [7:0]  status_in, event_in;
  logic        pready [3];
  logic        pslverr [3];
  logic        irq [3];
  logic [31:0] prdata [3];
  logic [31:0] ctrl_out [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mctrl [4];

  always #5 clk = ~clk;

  apb_reg_bank #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .paddr(paddr), .psel(psel[0]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
    .ctrl_out(ctrl_out[0]), .status_in(status_in),
    .event_in(event_in), .irq(irq[0]));

  apb_reg_bank #(.WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .paddr(paddr), .psel(psel[1]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
    .ctrl_out(ctrl_out[1]), .status_in(status_in),
    .event_in(event_in), .irq(irq[1]));

  apb_reg_bank #(.WAIT_STATES(2)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .paddr(paddr), .psel(psel[2]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]),
    .ctrl_out(ctrl_out[2]), .status_in(status_in),
    .event_in(event_in), .irq(irq[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a setup phase immediately; returns 1 time unit after the commit edge
  task automatic apb(input int i, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err,
                     output int cyc, output logic ok, output logic dirty);
    rd = '0; err = 1'b0; ok = 1'b0; dirty = 1'b0;
    psel[i] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    cyc = 1;
    tick();
    penable = 1'b1;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(negedge clk);
      cyc++;
      if (pready[i]) begin
        rd = prdata[i]; err = pslverr[i]; ok = 1'b1;
      end else if (prdata[i] != 0 || pslverr[i]) begin
        dirty = 1'b1;
      end
      tick();
    end
    psel[i] = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = '0; psel = '1; penable = 1'b1; pwrite = 1'b1;
    paddr = '0; pwdata = 32'hFF; status_in = '0; event_in = '0;
    repeat (3) tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pready[i] !== 1'b0 || prdata[i] !== 0 || pslverr[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_outputs[%0d]: pready=%b prdata=%h pslverr=%b want 0",
                 i, pready[i], prdata[i], pslverr[i]);
      end
      checks++;
      if (ctrl_out[i] !== 0 || irq[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_regs[%0d]: ctrl=%h irq=%b want 0", i, ctrl_out[i], irq[i]);
      end
    end
    psel = '0; penable = 1'b0;
    tick();
    rst_n = '1;
    tick();
    for (int k = 0; k < 4; k++) mctrl[k] = '0;
  endtask

  task automatic test_defaults();
    logic [31:0] rd; logic err, ok, dirty; int cyc; exp_t e;
    logic [31:0] mv;
    apb(0, 1'b1, 32'h4000, 32'hA5, rd, err, cyc, ok, dirty);
    mctrl[1] = 8'hA5;
    checks++;
    if (!ok || cyc !== 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL wr_ctrl1: ok=%b cyc=%0d err=%b want 1/2/0", ok, cyc, err);
    end
    checks++;
    if (ctrl_out[0][15:8] !== 8'hA5) begin
      errors++;
      $display("FAIL ctrl_out1: got %h want a5", ctrl_out[0][15:8]);
    end
    exp_q.push_back('{rd: 32'hA5, err: 1'b0});
    apb(0, 1'b0, 32'h4000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd || err !== e.err || cyc !== 2) begin
      errors++;
      $display("FAIL rd_ctrl1: rd=%h err=%b cyc=%0d want %h/%b/2", rd, err, cyc, e.rd, e.err);
    end
    // back-to-back writes then reads of every CTRL register
    for (int k = 0; k < 4; k++) begin
      mctrl[k] = 8'($urandom_range(1, 255));
      apb(0, 1'b1, 32'(k) << 14, {24'hFFFFFF, mctrl[k]}, rd, err, cyc, ok, dirty);
    end
    for (int k = 0; k < 4; k++) mv[k*8 +: 8] = mctrl[k];
    checks++;
    if (ctrl_out[0] !== mv) begin
      errors++;
      $display("FAIL ctrl_all: got %h want %h", ctrl_out[0], mv);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{rd: {24'h0, mctrl[k]}, err: 1'b0});
      apb(0, 1'b0, 32'(k) << 14, 32'h0, rd, err, cyc, ok, dirty);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rd !== e.rd || err !== e.err || cyc !== 2) begin
        errors++;
        $display("FAIL b2b_rd%0d: rd=%h err=%b cyc=%0d want %h/%b/2",
                 k, rd, err, cyc, e.rd, e.err);
      end
    end
    status_in = 8'h3C;
    tick();
    apb(0, 1'b1, 32'h10000, 32'hFF, rd, err, cyc, ok, dirty);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("FAIL wr_status: ok=%b err=%b want 1/0", ok, err);
    end
    exp_q.push_back('{rd: 32'h3C, err: 1'b0});
    apb(0, 1'b0, 32'h10000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd || err !== e.err) begin
      errors++;
      $display("FAIL rd_status: rd=%h err=%b want %h/%b", rd, err, e.rd, e.err);
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic err, ok, dirty; int cyc; exp_t e;
    apb(1, 1'b1, 32'h0, 32'h5A, rd, err, cyc, ok, dirty);
    checks++;
    if (!ok || cyc !== 5) begin
      errors++;
      $display("FAIL wait_wr: ok=%b cyc=%0d want 1/5", ok, cyc);
    end
    exp_q.push_back('{rd: 32'h5A, err: 1'b0});
    apb(1, 1'b0, 32'h0, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc !== 5 || rd !== e.rd || err !== e.err || dirty) begin
      errors++;
      $display("FAIL wait_rd: cyc=%0d rd=%h err=%b dirty=%b want 5/%h/%b/0",
               cyc, rd, err, dirty, e.rd, e.err);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic err, ok, dirty; int cyc; exp_t e;
    logic [31:0] mv;
    exp_q.push_back('{rd: 32'h0, err: 1'b1});
    apb(0, 1'b0, 32'h1C000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd || err !== e.err) begin
      errors++;
      $display("FAIL unmapped_rd: rd=%h err=%b want %h/%b", rd, err, e.rd, e.err);
    end
    apb(0, 1'b1, 32'h1C000, 32'hFF, rd, err, cyc, ok, dirty);
    checks++;
    if (!ok || err !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_wr: ok=%b err=%b want 1/1", ok, err);
    end
    for (int k = 0; k < 4; k++) mv[k*8 +: 8] = mctrl[k];
    checks++;
    if (ctrl_out[0] !== mv) begin
      errors++;
      $display("FAIL unmapped_ctrl: got %h want %h", ctrl_out[0], mv);
    end
    for (int r = 5; r <= 6; r++) begin
      exp_q.push_back('{rd: 32'h0, err: 1'b0});
      apb(0, 1'b0, 32'(r) << 14, 32'h0, rd, err, cyc, ok, dirty);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rd !== e.rd || err !== e.err) begin
        errors++;
        $display("FAIL unmapped_idx%0d: rd=%h err=%b want %h/%b", r, rd, err, e.rd, e.err);
      end
    end
    exp_q.push_back('{rd: {24'h0, mctrl[1]}, err: 1'b0});
    apb(0, 1'b0, 32'h8000_4000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd || err !== e.err) begin
      errors++;
      $display("FAIL bit31_ignored: rd=%h err=%b want %h/%b", rd, err, e.rd, e.err);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err, ok, dirty; int cyc; exp_t e;
    apb(0, 1'b1, 32'h18000, 32'h01, rd, err, cyc, ok, dirty);
    event_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL irq_edge1: got %b want 0", irq[0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL irq_edge2: got %b want 1", irq[0]);
    end
    tick();
    event_in[0] = 1'b0;
    exp_q.push_back('{rd: 32'h01, err: 1'b0});
    apb(0, 1'b0, 32'h14000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd) begin
      errors++;
      $display("FAIL pend_set: rd=%h want %h", rd, e.rd);
    end
    apb(0, 1'b1, 32'h14000, 32'h01, rd, err, cyc, ok, dirty);
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL irq_clr_edge1: got %b want 1", irq[0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr_edge2: got %b want 0", irq[0]);
    end
    tick();
    event_in[1] = 1'b1;
    repeat (3) tick();
    event_in[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: got %b want 0", irq[0]);
    end
    tick();
    exp_q.push_back('{rd: 32'h02, err: 1'b0});
    apb(0, 1'b0, 32'h14000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd) begin
      errors++;
      $display("FAIL pend1_set: rd=%h want %h", rd, e.rd);
    end
    apb(0, 1'b1, 32'h14000, 32'h02, rd, err, cyc, ok, dirty);
  endtask

  task automatic test_collision();
    logic [31:0] rd; logic err, ok, dirty; int cyc; exp_t e;
    event_in[0] = 1'b1;
    tick(); tick();
    event_in[0] = 1'b0;
    tick();
    fork
      apb(0, 1'b1, 32'h14000, 32'h01, rd, err, cyc, ok, dirty);
      begin
        @(posedge clk);
        #1 event_in[0] = 1'b1;
      end
    join
    exp_q.push_back('{rd: 32'h01, err: 1'b0});
    apb(0, 1'b0, 32'h14000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd) begin
      errors++;
      $display("FAIL set_wins: pend=%h want %h", rd, e.rd);
    end
    event_in[0] = 1'b0;
    tick();
    apb(0, 1'b1, 32'h14000, 32'h01, rd, err, cyc, ok, dirty);
    exp_q.push_back('{rd: 32'h00, err: 1'b0});
    apb(0, 1'b0, 32'h14000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd) begin
      errors++;
      $display("FAIL w1c_clear: pend=%h want %h", rd, e.rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err, ok, dirty; int cyc; exp_t e;
    logic seen;
    seen = 1'b0;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4000; pwdata = 32'h77;
    tick();
    penable = 1'b1;
    @(negedge clk);
    seen |= pready[1];
    tick();
    psel[1] = 1'b0; penable = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      seen |= pready[1];
      tick();
    end
    checks++;
    if (seen !== 1'b0 || ctrl_out[1][15:8] !== 8'h00) begin
      errors++;
      $display("FAIL psel_abort: pready_seen=%b ctrl1=%h want 0/00", seen, ctrl_out[1][15:8]);
    end
    exp_q.push_back('{rd: 32'h0, err: 1'b0});
    apb(1, 1'b0, 32'h4000, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd || cyc !== 5) begin
      errors++;
      $display("FAIL post_abort_rd: rd=%h cyc=%0d want %h/5", rd, cyc, e.rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic err, ok, dirty; int cyc; exp_t e;
    logic seen;
    seen = 1'b0;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0; pwdata = 32'h3C;
    tick();
    penable = 1'b1;
    @(negedge clk);
    seen |= pready[2];
    tick();
    rst_n[2] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      seen |= pready[2];
      tick();
    end
    rst_n[2] = 1'b1;
    psel[2] = 1'b0; penable = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      seen |= pready[2];
      tick();
    end
    checks++;
    if (seen !== 1'b0 || ctrl_out[2] !== 32'h0) begin
      errors++;
      $display("FAIL rst_abort: pready_seen=%b ctrl=%h want 0/0", seen, ctrl_out[2]);
    end
    apb(2, 1'b1, 32'h0, 32'h3C, rd, err, cyc, ok, dirty);
    checks++;
    if (!ok || cyc !== 4 || ctrl_out[2][7:0] !== 8'h3C) begin
      errors++;
      $display("FAIL ws2_wr: ok=%b cyc=%0d ctrl0=%h want 1/4/3c", ok, cyc, ctrl_out[2][7:0]);
    end
    exp_q.push_back('{rd: 32'h3C, err: 1'b0});
    apb(2, 1'b0, 32'h0, 32'h0, rd, err, cyc, ok, dirty);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rd || cyc !== 4) begin
      errors++;
      $display("FAIL ws2_rd: rd=%h cyc=%0d want %h/4", rd, cyc, e.rd);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_wait();
    test_unmapped();
    test_irq();
    test_collision();
    test_abort();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
